// File: rtl/icache_ctrl.sv
// Two-way L1 instruction-cache controller.
// Sits between the fetch stage and the tag/data RAMs. It resolves hit/miss,
// refills a victim way from L2 on a miss, and runs a whole-cache invalidate
// sweep when asked to flush.
module icache_ctrl #(
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   input  logic               flush,
   output logic [31:0]        insn,
   output logic               insn_valid,
   output logic               busy,
   output logic [INDEX_W-1:0] index,
   output logic               tag0_rw,
   output logic               tag1_rw,
   output logic [TAG_W:0]     tag_wd,
   input  logic [TAG_W:0]     tag0_rd,
   input  logic [TAG_W:0]     tag1_rd,
   input  logic               lru,
   input  logic               complete,
   output logic               data0_rw,
   output logic               data1_rw,
   output logic [127:0]       data_wd,
   output logic               data_wd_l2_en,
   input  logic [127:0]       data0_rd,
   input  logic [127:0]       data1_rd,
   output logic               l2_req,
   output logic [27:0]        l2_addr,
   input  logic               l2_rdy,
   input  logic [127:0]       l2_data
);

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;
   localparam logic [INDEX_W-1:0] CNT_ONE = INDEX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_REFILL,
      S_WRITE,
      S_DONE,
      S_FLUSH
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [31:0]          r_addr;
   logic                 r_victim;
   logic [127:0]         r_line;
   logic [INDEX_W-1:0]   r_count;
   logic                 r_pendFlush;
   logic                 r_rstDone;

   logic                 w_latchAddr;
   logic                 w_captureVictim;
   logic [TAG_W-1:0]     w_addrTag;
   logic [INDEX_W-1:0]   w_addrIndex;
   logic [1:0]           w_word;
   logic                 w_hit0;
   logic                 w_hit1;
   logic                 w_hit;
   logic                 w_victim;
   logic [127:0]         w_hitLine;
   logic [31:0]          w_hitWord;
   logic [31:0]          w_lineWord;
   logic                 w_flushDefer;
   logic                 w_unusedBits;

   // Field split of the latched fetch address; the byte offset is not needed.
   assign w_addrTag    = r_addr[31 -: TAG_W];
   assign w_addrIndex  = r_addr[4 +: INDEX_W];
   assign w_word       = r_addr[3:2];
   assign w_unusedBits = ^r_addr[1:0];
   assign l2_addr      = r_addr[31:4];

   // Hit detection: way0 wins if both ways claim the line.
   assign w_hit0 = tag0_rd[TAG_W] && (tag0_rd[TAG_W-1:0] == w_addrTag);
   assign w_hit1 = tag1_rd[TAG_W] && (tag1_rd[TAG_W-1:0] == w_addrTag);
   assign w_hit  = w_hit0 || w_hit1;

   // Victim choice: fill an empty way first, otherwise follow the LRU bit.
   assign w_victim = !tag0_rd[TAG_W] ? 1'b0 :
                     !tag1_rd[TAG_W] ? 1'b1 : lru;

   // Word selection for a hit and for the freshly refilled line.
   assign w_hitLine  = w_hit0 ? data0_rd : data1_rd;
   assign w_hitWord  = w_hitLine[{w_word, 5'b0} +: 32];
   assign w_lineWord = r_line[{w_word, 5'b0} +: 32];

   // A flush that lands while a refill is in flight is deferred until it completes.
   assign w_flushDefer = flush && ((r_state == S_ACCESS && !w_hit) ||
                                   (r_state == S_REFILL) ||
                                   (r_state == S_WRITE)  ||
                                   (r_state == S_DONE));

   // State register plus a flag that keeps busy high for the first cycle after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_rstDone <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_rstDone <= 1'b1;
      end
   end

   // Capture the fetch address, the chosen victim and the returning L2 line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_victim <= 1'b0;
         r_line   <= '0;
      end else begin
         if (w_latchAddr) begin
            r_addr <= if_addr;
         end
         if (w_captureVictim) begin
            r_victim <= w_victim;
         end
         if (r_state == S_REFILL && l2_rdy) begin
            r_line <= l2_data;
         end
      end
   end

   // Sweep counter restarts on entry to the flush sweep and steps once per set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (w_nextState == S_FLUSH && r_state != S_FLUSH) begin
         r_count <= '0;
      end else if (r_state == S_FLUSH) begin
         r_count <= r_count + CNT_ONE;
      end
   end

   // Remember a deferred flush until the sweep actually starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pendFlush <= 1'b0;
      end else if (w_nextState == S_FLUSH) begin
         r_pendFlush <= 1'b0;
      end else if (w_flushDefer) begin
         r_pendFlush <= 1'b1;
      end
   end

   // Next-state and output decode; every output has a safe default first.
   always_comb begin
      w_nextState     = r_state;
      w_latchAddr     = 1'b0;
      w_captureVictim = 1'b0;
      insn            = '0;
      insn_valid      = 1'b0;
      busy            = 1'b1;
      index           = w_addrIndex;
      tag0_rw         = RAM_READ;
      tag1_rw         = RAM_READ;
      tag_wd          = '0;
      data0_rw        = RAM_READ;
      data1_rw        = RAM_READ;
      data_wd         = '0;
      data_wd_l2_en   = 1'b0;
      l2_req          = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy = ~r_rstDone;
            if (flush) begin
               w_nextState = S_FLUSH;
            end else if (if_req && r_rstDone) begin
               w_latchAddr = 1'b1;
               w_nextState = S_ACCESS;
            end
         end

         S_ACCESS: begin
            if (w_hit) begin
               insn       = w_hitWord;
               insn_valid = 1'b1;
               busy       = 1'b0;
               if (flush) begin
                  w_nextState = S_FLUSH;
               end else if (if_req) begin
                  w_latchAddr = 1'b1;
                  w_nextState = S_ACCESS;
               end else begin
                  w_nextState = S_IDLE;
               end
            end else begin
               w_captureVictim = 1'b1;
               w_nextState     = S_REFILL;
            end
         end

         S_REFILL: begin
            l2_req = 1'b1;
            if (l2_rdy) begin
               w_nextState = S_WRITE;
            end
         end

         S_WRITE: begin
            tag0_rw       = r_victim ? RAM_READ  : RAM_WRITE;
            tag1_rw       = r_victim ? RAM_WRITE : RAM_READ;
            data0_rw      = r_victim ? RAM_READ  : RAM_WRITE;
            data1_rw      = r_victim ? RAM_WRITE : RAM_READ;
            tag_wd        = {1'b1, w_addrTag};
            data_wd       = r_line;
            data_wd_l2_en = 1'b1;
            w_nextState   = S_DONE;
         end

         S_DONE: begin
            if (complete) begin
               insn        = w_lineWord;
               insn_valid  = 1'b1;
               w_nextState = (r_pendFlush || flush) ? S_FLUSH : S_IDLE;
            end
         end

         S_FLUSH: begin
            index   = r_count;
            tag0_rw = RAM_WRITE;
            tag1_rw = RAM_WRITE;
            tag_wd  = '0;
            if (r_count == '1) begin
               w_nextState = S_IDLE;
            end
         end

         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

endmodule
